// File: rtl/bbox_stimulus_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : bbox_stimulus_gen_if
// Purpose  : Control and box-coordinate bundle for bbox_stimulus_gen.
// Revision : 1.0  initial release
// ============================================================================
interface bbox_stimulus_gen_if #(
  parameter int X_WIDTH = 9,
  parameter int Y_WIDTH = 8
);
  logic               iEnable;
  logic               iRestart;
  logic               iMode;
  logic               oNewCoord;
  logic [X_WIDTH-1:0] oXmin;
  logic [X_WIDTH-1:0] oXmax;
  logic [Y_WIDTH-1:0] oYmin;
  logic [Y_WIDTH-1:0] oYmax;
  logic               oFrameDone;

  modport master (
    output iEnable, iRestart, iMode,
    input  oNewCoord, oXmin, oXmax, oYmin, oYmax, oFrameDone
  );

  modport slave (
    input  iEnable, iRestart, iMode,
    output oNewCoord, oXmin, oXmax, oYmin, oYmax, oFrameDone
  );
endinterface
`default_nettype wire

// File: rtl/bbox_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module   : bbox_stimulus_gen
// Purpose  : Moves a fixed-size box across a frame (raster or bounce), holding
//            each position for DWELL_CYCLES enabled cycles.
// Options  : BBOX_STIM_BOUNCE_EN - adds bounce mode (iMode=1) and dx/dy state.
// Revision : 1.0  initial release
// ============================================================================
module bbox_stimulus_gen #(
  parameter int          X_WIDTH      = 9,
  parameter int          Y_WIDTH      = 8,
  parameter int          X_LIMIT      = 320,
  parameter int          Y_LIMIT      = 240,
  parameter int          BOX_W        = 14,
  parameter int          BOX_H        = 10,
  parameter int          X_STEP       = 16,
  parameter int          Y_STEP       = 16,
  parameter int unsigned DWELL_CYCLES = 32'h004F0000
) (
  input wire               iClock,
  input wire               iReset,
  bbox_stimulus_gen_if.slave bus
);

  localparam int             c_XMAX       = X_LIMIT - BOX_W;
  localparam int             c_YMAX       = Y_LIMIT - BOX_H;
  // One bit wider than the coordinate so x+step never wraps before comparing
  localparam logic [X_WIDTH:0]   c_XMAX_W   = (X_WIDTH+1)'(c_XMAX);
  localparam logic [Y_WIDTH:0]   c_YMAX_W   = (Y_WIDTH+1)'(c_YMAX);
  localparam logic [X_WIDTH:0]   c_XSTEP_W  = (X_WIDTH+1)'(X_STEP);
  localparam logic [Y_WIDTH:0]   c_YSTEP_W  = (Y_WIDTH+1)'(Y_STEP);
  localparam logic [X_WIDTH-1:0] c_XBOX     = X_WIDTH'(BOX_W - 1);
  localparam logic [Y_WIDTH-1:0] c_YBOX     = Y_WIDTH'(BOX_H - 1);
  localparam logic [31:0]        c_DWELL_LAST = 32'(DWELL_CYCLES - 1);

  logic [X_WIDTH-1:0] r_x;
  logic [Y_WIDTH-1:0] r_y;
  logic [X_WIDTH-1:0] r_xmax;
  logic [Y_WIDTH-1:0] r_ymax;
  logic [31:0]        r_cnt;
  logic               r_new;
  logic               r_frame;

  logic [X_WIDTH:0]   w_x_fwd;
  logic [Y_WIDTH:0]   w_y_fwd;
  logic               w_adv;
  logic [X_WIDTH-1:0] w_rast_x;
  logic [Y_WIDTH-1:0] w_rast_y;
  logic               w_rast_fd;
  logic [X_WIDTH-1:0] w_nx;
  logic [Y_WIDTH-1:0] w_ny;
  logic               w_nfd;

  assign w_x_fwd = {1'b0, r_x} + c_XSTEP_W;
  assign w_y_fwd = {1'b0, r_y} + c_YSTEP_W;
  assign w_adv   = bus.iEnable && (r_cnt == c_DWELL_LAST);

  // Raster: step x along the row, wrap to the next row, wrap y at frame end
  always_comb begin
    w_rast_x  = r_x;
    w_rast_y  = r_y;
    w_rast_fd = 1'b0;
    if (w_x_fwd <= c_XMAX_W) begin
      w_rast_x = w_x_fwd[X_WIDTH-1:0];
    end else begin
      w_rast_x = '0;
      if (w_y_fwd <= c_YMAX_W) begin
        w_rast_y = w_y_fwd[Y_WIDTH-1:0];
      end else begin
        w_rast_y  = '0;
        w_rast_fd = 1'b1;
      end
    end
  end

`ifdef BBOX_STIM_BOUNCE_EN
  localparam logic [X_WIDTH-1:0] c_XMAX_N  = X_WIDTH'(c_XMAX);
  localparam logic [Y_WIDTH-1:0] c_YMAX_N  = Y_WIDTH'(c_YMAX);
  localparam logic [X_WIDTH-1:0] c_XSTEP_N = X_WIDTH'(X_STEP);
  localparam logic [Y_WIDTH-1:0] c_YSTEP_N = Y_WIDTH'(Y_STEP);

  // Direction flags: 0 = increasing, 1 = decreasing
  logic               r_dx;
  logic               r_dy;
  logic [X_WIDTH-1:0] w_bnc_x;
  logic [Y_WIDTH-1:0] w_bnc_y;
  logic               w_bnc_dx;
  logic               w_bnc_dy;
  logic               w_bounce;

  assign w_bounce = bus.iMode;

  always_comb begin
    w_bnc_x  = r_x;
    w_bnc_dx = r_dx;
    if (!r_dx) begin
      if (w_x_fwd > c_XMAX_W) begin
        w_bnc_x  = c_XMAX_N;
        w_bnc_dx = 1'b1;
      end else begin
        w_bnc_x  = w_x_fwd[X_WIDTH-1:0];
      end
    end else if ({1'b0, r_x} < c_XSTEP_W) begin
      w_bnc_x  = '0;
      w_bnc_dx = 1'b0;
    end else begin
      w_bnc_x  = r_x - c_XSTEP_N;
    end
  end

  always_comb begin
    w_bnc_y  = r_y;
    w_bnc_dy = r_dy;
    if (!r_dy) begin
      if (w_y_fwd > c_YMAX_W) begin
        w_bnc_y  = c_YMAX_N;
        w_bnc_dy = 1'b1;
      end else begin
        w_bnc_y  = w_y_fwd[Y_WIDTH-1:0];
      end
    end else if ({1'b0, r_y} < c_YSTEP_W) begin
      w_bnc_y  = '0;
      w_bnc_dy = 1'b0;
    end else begin
      w_bnc_y  = r_y - c_YSTEP_N;
    end
  end

  always_comb begin
    w_nx  = w_rast_x;
    w_ny  = w_rast_y;
    w_nfd = w_rast_fd;
    if (w_bounce) begin
      w_nx  = w_bnc_x;
      w_ny  = w_bnc_y;
      w_nfd = 1'b0;
    end
  end

  // Direction only changes on a bounce-mode advance; restart forces increasing
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_dx <= 1'b0;
      r_dy <= 1'b0;
    end else if (bus.iRestart) begin
      r_dx <= 1'b0;
      r_dy <= 1'b0;
    end else if (w_adv && w_bounce) begin
      r_dx <= w_bnc_dx;
      r_dy <= w_bnc_dy;
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = bus.iMode;
  assign w_nx          = w_rast_x;
  assign w_ny          = w_rast_y;
  assign w_nfd         = w_rast_fd;
`endif

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_xmax  <= c_XBOX;
      r_ymax  <= c_YBOX;
      r_cnt   <= '0;
      r_new   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_new   <= 1'b0;
      r_frame <= 1'b0;
      if (bus.iRestart) begin
        r_x    <= '0;
        r_y    <= '0;
        r_xmax <= c_XBOX;
        r_ymax <= c_YBOX;
        r_cnt  <= '0;
        r_new  <= 1'b1;
      end else if (w_adv) begin
        r_x     <= w_nx;
        r_y     <= w_ny;
        r_xmax  <= w_nx + c_XBOX;
        r_ymax  <= w_ny + c_YBOX;
        r_cnt   <= '0;
        r_new   <= 1'b1;
        r_frame <= w_nfd;
      end else if (bus.iEnable) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign bus.oXmin      = r_x;
  assign bus.oXmax      = r_xmax;
  assign bus.oYmin      = r_y;
  assign bus.oYmax      = r_ymax;
  assign bus.oNewCoord  = r_new;
  assign bus.oFrameDone = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_bbox_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbox_stimulus_gen
// Purpose  : Self-checking bench for bbox_stimulus_gen against a closed-form
//            position model (advance count -> box position).
// Revision : 1.0  initial release
// ============================================================================
module tb_bbox_stimulus_gen;
  localparam int XW = 9, YW = 8, XL = 320, YL = 240, BW = 14, BH = 10;
  localparam int XS = 16, YS = 16, DW = 4;
  localparam int XMAX = XL - BW, YMAX = YL - BH;
  localparam int COLS = XMAX / XS + 1, ROWS = YMAX / YS + 1;
`ifdef BBOX_STIM_BOUNCE_EN
  localparam bit BOUNCE_ON = 1'b1;
`else
  localparam bit BOUNCE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model state: advances since restart, enabled cycles into the dwell
  int n_adv, cnt_m, ex_x, ex_y;
  bit mode_m, ex_new, ex_fd;

  bbox_stimulus_gen_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  bbox_stimulus_gen #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .X_LIMIT(XL), .Y_LIMIT(YL),
    .BOX_W(BW), .BOX_H(BH), .X_STEP(XS), .Y_STEP(YS), .DWELL_CYCLES(DW)
  ) dut (
    .iClock (clk),
    .iReset (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Bounce path over one period: 0, st, .., m*st, mx, mx-st, .., mx-m*st
  function automatic int bounce_pos(input int n, input int mx, input int st);
    int m, i;
    m = mx / st;
    i = n % (2 * m + 2);
    if (i <= m)          return i * st;
    else if (i == m + 1) return mx;
    else                 return mx - (i - m - 1) * st;
  endfunction

  function automatic void set_expected_pos();
    int idx;
    if (mode_m && BOUNCE_ON) begin
      ex_x = bounce_pos(n_adv, XMAX, XS);
      ex_y = bounce_pos(n_adv, YMAX, YS);
    end else begin
      idx  = n_adv % (COLS * ROWS);
      ex_x = (idx % COLS) * XS;
      ex_y = (idx / COLS) * YS;
    end
  endfunction

  function automatic void model_reset(input bit md);
    n_adv = 0; cnt_m = 0; ex_new = 1'b0; ex_fd = 1'b0; mode_m = md;
    set_expected_pos();
  endfunction

  function automatic bit dut_matches_model();
    return bus.oXmin === XW'(ex_x) && bus.oXmax === XW'(ex_x + BW - 1) &&
           bus.oYmin === YW'(ex_y) && bus.oYmax === YW'(ex_y + BH - 1) &&
           bus.oNewCoord === ex_new && bus.oFrameDone === ex_fd;
  endfunction

  function automatic string got_str();
    return $sformatf("x=%0d..%0d y=%0d..%0d new=%b fd=%b", bus.oXmin, bus.oXmax,
                     bus.oYmin, bus.oYmax, bus.oNewCoord, bus.oFrameDone);
  endfunction

  function automatic string exp_str();
    return $sformatf("x=%0d..%0d y=%0d..%0d new=%b fd=%b", ex_x, ex_x + BW - 1,
                     ex_y, ex_y + BH - 1, ex_new, ex_fd);
  endfunction

  // Drive one cycle of inputs, then advance the model past that edge
  task automatic tick(input bit en, input bit rs, input bit md);
    @(negedge clk);
    bus.iEnable = en; bus.iRestart = rs; bus.iMode = md;
    @(posedge clk);
    #1;
    ex_new = 1'b0; ex_fd = 1'b0;
    if (rs) begin
      n_adv = 0; cnt_m = 0; ex_new = 1'b1; mode_m = md;
    end else if (en) begin
      if (cnt_m == DW - 1) begin
        cnt_m = 0; n_adv++; ex_new = 1'b1;
        if (!(mode_m && BOUNCE_ON) && (n_adv % (COLS * ROWS)) == 0) ex_fd = 1'b1;
      end else begin
        cnt_m++;
      end
    end
    set_expected_pos();
  endtask

  task automatic test_reset();
    bus.iEnable = 1'b0; bus.iRestart = 1'b0; bus.iMode = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.oXmin !== 9'd0 || bus.oXmax !== 9'd13 || bus.oYmin !== 8'd0 ||
        bus.oYmax !== 8'd9 || bus.oNewCoord !== 1'b0 || bus.oFrameDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got %s, expected x=0..13 y=0..9 new=0 fd=0", got_str());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(1'b0);
  endtask

  task automatic test_raster_first();
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (!dut_matches_model()) begin
        errors++;
        $display("FAIL first_dwell cyc%0d: got %s, expected %s", i, got_str(), exp_str());
      end
      if (i == 3) begin
        checks++;
        if (bus.oNewCoord !== 1'b0) begin
          errors++;
          $display("FAIL early_strobe: got new=%b, expected 0", bus.oNewCoord);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.oNewCoord !== 1'b1 || bus.oXmin !== 9'd16 || bus.oXmax !== 9'd29) begin
          errors++;
          $display("FAIL first_advance: got %s, expected new=1 x=16..29", got_str());
        end
      end
    end
  endtask

  task automatic test_raster_frame();
    int budget;
    tick(1'b0, 1'b1, 1'b0);
    checks++;
    if (!dut_matches_model()) begin
      errors++;
      $display("FAIL frame_restart: got %s, expected %s", got_str(), exp_str());
    end
    budget = 0;
    while (n_adv < COLS * ROWS + 2 && budget < 8000) begin
      tick(($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      budget++;
      checks++;
      if (!dut_matches_model()) begin
        errors++;
        $display("FAIL raster_walk n=%0d: got %s, expected %s", n_adv, got_str(), exp_str());
      end
      if (ex_new && n_adv == COLS) begin
        checks++;
        if (bus.oXmin !== 9'd0 || bus.oYmin !== 8'd16 || bus.oFrameDone !== 1'b0) begin
          errors++;
          $display("FAIL row_wrap: got %s, expected x=0 y=16 fd=0", got_str());
        end
      end
      if (ex_new && n_adv == COLS * ROWS) begin
        checks++;
        if (bus.oXmin !== 9'd0 || bus.oYmin !== 8'd0 || bus.oFrameDone !== 1'b1 ||
            bus.oNewCoord !== 1'b1) begin
          errors++;
          $display("FAIL frame_wrap: got %s, expected x=0 y=0 new=1 fd=1", got_str());
        end
      end
    end
    checks++;
    if (n_adv < COLS * ROWS + 2) begin
      errors++;
      $display("FAIL frame_budget: got %0d advances, expected %0d", n_adv, COLS * ROWS + 2);
    end
  endtask

  task automatic test_enable_hold();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (!dut_matches_model() || bus.oNewCoord !== 1'b0) begin
        errors++;
        $display("FAIL hold_cyc%0d: got %s, expected %s", i, got_str(), exp_str());
      end
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.oNewCoord !== 1'b0) begin
      errors++;
      $display("FAIL reenable_1: got new=%b, expected 0", bus.oNewCoord);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.oNewCoord !== 1'b1 || bus.oXmin !== 9'd16 || !dut_matches_model()) begin
      errors++;
      $display("FAIL reenable_2: got %s, expected new=1 x=16..29", got_str());
    end
  endtask

  task automatic test_restart_priority();
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10 * DW + DW - 1; i++) tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.oXmin !== 9'd160 || bus.oXmax !== 9'd173) begin
      errors++;
      $display("FAIL pre_restart_pos: got %s, expected x=160..173", got_str());
    end
    tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.oXmin !== 9'd0 || bus.oXmax !== 9'd13 || bus.oYmin !== 8'd0 ||
        bus.oYmax !== 8'd9 || bus.oNewCoord !== 1'b1 || bus.oFrameDone !== 1'b0) begin
      errors++;
      $display("FAIL restart_vs_advance: got %s, expected x=0..13 y=0..9 new=1 fd=0", got_str());
    end
    for (int i = 0; i < 2 * DW + 1; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    checks++;
    if (!dut_matches_model() || bus.oNewCoord !== 1'b1 || bus.oXmin !== 9'd0) begin
      errors++;
      $display("FAIL restart_disabled: got %s, expected %s", got_str(), exp_str());
    end
  endtask

  task automatic test_mode_glitch();
    bit en, md;
    int budget;
    tick(1'b0, 1'b1, 1'b0);
    budget = 0;
    while (n_adv < 25 && budget < 1000) begin
      en = ($urandom_range(0, 3) != 0);
      md = (en && cnt_m == DW - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      tick(en, 1'b0, md);
      budget++;
      checks++;
      if (!dut_matches_model()) begin
        errors++;
        $display("FAIL mode_glitch n=%0d: got %s, expected %s", n_adv, got_str(), exp_str());
      end
    end
    bus.iMode = 1'b0;
  endtask

  task automatic test_bounce();
    int budget;
    int exp_x20, exp_x21;
    exp_x20 = BOUNCE_ON ? 306 : 0;
    exp_x21 = BOUNCE_ON ? 290 : 16;
    tick(1'b0, 1'b1, 1'b1);
    budget = 0;
    while (n_adv < 70 && budget < 2000) begin
      tick(($urandom_range(0, 3) != 0), 1'b0, 1'b1);
      budget++;
      checks++;
      if (!dut_matches_model()) begin
        errors++;
        $display("FAIL bounce_walk n=%0d: got %s, expected %s", n_adv, got_str(), exp_str());
      end
      if (ex_new && n_adv == 20) begin
        checks++;
        if (bus.oXmin !== XW'(exp_x20) || bus.oXmax !== XW'(exp_x20 + BW - 1)) begin
          errors++;
          $display("FAIL bounce_edge: got %s, expected x=%0d..%0d", got_str(), exp_x20, exp_x20 + BW - 1);
        end
      end
      if (ex_new && n_adv == 21) begin
        checks++;
        if (bus.oXmin !== XW'(exp_x21)) begin
          errors++;
          $display("FAIL bounce_turn: got x=%0d, expected %0d", bus.oXmin, exp_x21);
        end
      end
    end
    checks++;
    if (n_adv < 70) begin
      errors++;
      $display("FAIL bounce_budget: got %0d advances, expected 70", n_adv);
    end
    tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.oXmin !== 9'd0 || bus.oXmax !== 9'd13 || bus.oYmin !== 8'd0 ||
        bus.oYmax !== 8'd9 || bus.oNewCoord !== 1'b0 || bus.oFrameDone !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %s, expected x=0..13 y=0..9 new=0 fd=0", got_str());
    end
    @(negedge clk);
    bus.iEnable = 1'b0; bus.iRestart = 1'b0;
    rst_n = 1'b1;
    model_reset(1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (!dut_matches_model() || bus.oNewCoord !== (i == 4)) begin
        errors++;
        $display("FAIL post_reset_cyc%0d: got %s, expected %s", i, got_str(), exp_str());
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster_first();
    test_raster_frame();
    test_enable_hold();
    test_restart_priority();
    test_mode_glitch();
    test_bounce();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
